// File: rtl/mac_acc_pkg.sv
// Shared types for the MAC accumulator bank: command op encoding and drain FSM states.
package mac_acc_pkg;

    typedef enum logic [1:0] {
        OP_ACC   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/mac_acc_sat_add.sv
// Combinational accumulator adder: ACC_W accumulator plus sign-extended DATA_W operand.
// Reports signed overflow; clamps to the ACC_W range when MAC_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_W.
module mac_acc_sat_add #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;

    // One guard bit: overflow when the guard and the ACC_W sign bit disagree
    always_comb begin
        wide = {acc[ACC_W-1], acc} + (ACC_W+1)'($signed(data));
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
`ifdef MAC_ACC_SAT_EN
        if (ovf) begin
            sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = wide[ACC_W-1:0];
        end
`else
        sum = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_acc_bank.sv
// Multi-channel signed accumulator bank with valid/ready command port and a
// flush-triggered drain sequencer streaming every channel over a valid/ready port.
// Optional build macro: MAC_ACC_SAT_EN (saturating accumulate instead of wrapping).
module mac_acc_bank
    import mac_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e            state_q;
    logic [CH_W-1:0]   ptr_q;
    logic [ACC_W-1:0]  out_data_q;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    logic              fire;
    op_e               cmd_op;
    logic [ACC_W-1:0]  sel_acc;
    logic [ACC_W-1:0]  ext_data;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic [CH_W-1:0]   ptr_nxt;
    logic [ACC_W-1:0]  nxt_word;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == DRAIN);
    assign out_valid = (state_q == DRAIN);
    assign out_ch    = ptr_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;

    assign fire     = in_valid && in_ready;
    assign cmd_op   = op_e'(in_op);
    assign ext_data = ACC_W'($signed(in_data));
    assign ptr_nxt  = ptr_q + 1'b1;

    // Channel mux feeding the shared adder, and the next word for the drain stream
    always_comb begin
        sel_acc  = '0;
        nxt_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                sel_acc = acc_q[i];
            end
            if (ptr_nxt == CH_W'(i)) begin
                nxt_word = acc_q[i];
            end
        end
    end

    mac_acc_sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc  (sel_acc),
        .data (in_data),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // Next-state of accumulators and overflow flags; out-of-range channels match no slot
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (fire && in_ch == CH_W'(i)) begin
                case (cmd_op)
                    OP_ACC: begin
                        acc_d[i] = add_sum;
                        if (add_ovf) begin
                            ovf_d[i] = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        acc_d[i] = ext_data;
                        ovf_d[i] = 1'b0;
                    end
                    OP_CLEAR: begin
                        acc_d[i] = '0;
                        ovf_d[i] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Accumulator and sticky overflow storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Drain sequencer; the first word is taken from acc_d so a same-cycle command is visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q    <= DRAIN;
                        ptr_q      <= '0;
                        out_data_q <= acc_d[0];
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (ptr_q == LAST_CH) begin
                            state_q    <= IDLE;
                            ptr_q      <= '0;
                            out_data_q <= '0;
                        end else begin
                            ptr_q      <= ptr_nxt;
                            out_data_q <= nxt_word;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
